// File: rtl/vga_timing_gen.sv
// vga_timing_gen: horizontal/vertical pixel counters and a sync/DE delay line.
// The delay line lines raw timing up with the renderer's RGB before the registered DAC output.
`default_nettype none

module vga_timing_gen #(
  parameter int PIX_WIDTH    = 12,
  parameter int H_ACTIVE     = 1280,
  parameter int H_FP         = 48,
  parameter int H_SYNC       = 112,
  parameter int H_BP         = 248,
  parameter int V_ACTIVE     = 1024,
  parameter int V_FP         = 1,
  parameter int V_SYNC       = 3,
  parameter int V_BP         = 38,
  parameter bit HSYNC_POL    = 1'b1,
  parameter bit VSYNC_POL    = 1'b1,
  parameter int DATA_LATENCY = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  output logic [PIX_WIDTH-1:0] pix_x_o,
  output logic [PIX_WIDTH-1:0] pix_y_o,
  output logic                 frame_start_o,
  input  logic [23:0]          vga_data_i,
  input  logic                 vga_data_en_i,
  output logic [23:0]          vga_rgb_o,
  output logic                 vga_hs_o,
  output logic                 vga_vs_o,
  output logic                 vga_de_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // One extra bit so a boundary equal to 2**PIX_WIDTH still compares correctly.
  localparam int CW = PIX_WIDTH + 1;

  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_BEGIN = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_BEGIN = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);

  logic [CW-1:0] h_ext;
  logic [CW-1:0] v_ext;
  logic          de_raw;
  logic          hs_raw;
  logic          vs_raw;
  logic          de_d;
  logic          hs_d;
  logic          vs_d;

  logic [DATA_LATENCY-1:0] de_sr;
  logic [DATA_LATENCY-1:0] hs_sr;
  logic [DATA_LATENCY-1:0] vs_sr;

  assign h_ext = {1'b0, pix_x_o};
  assign v_ext = {1'b0, pix_y_o};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pix_x_o <= '0;
      pix_y_o <= '0;
    end else if (h_ext == H_LAST) begin
      pix_x_o <= '0;
      if (v_ext == V_LAST) begin
        pix_y_o <= '0;
      end else begin
        pix_y_o <= pix_y_o + PIX_WIDTH'(1);
      end
    end else begin
      pix_x_o <= pix_x_o + PIX_WIDTH'(1);
    end
  end

  assign frame_start_o = (pix_x_o == '0) && (pix_y_o == '0);

  assign de_raw = (h_ext < H_ACT) && (v_ext < V_ACT);
  assign hs_raw = (h_ext >= HS_BEGIN) && (h_ext < HS_END);
  assign vs_raw = (v_ext >= VS_BEGIN) && (v_ext < VS_END);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      de_sr <= '0;
      hs_sr <= '0;
      vs_sr <= '0;
    end else begin
      de_sr <= DATA_LATENCY'({de_sr, de_raw});
      hs_sr <= DATA_LATENCY'({hs_sr, hs_raw});
      vs_sr <= DATA_LATENCY'({vs_sr, vs_raw});
    end
  end

  assign de_d = de_sr[DATA_LATENCY-1];
  assign hs_d = hs_sr[DATA_LATENCY-1];
  assign vs_d = vs_sr[DATA_LATENCY-1];

  // Blanking wins: renderer data outside the active region never reaches the DAC.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vga_rgb_o <= 24'h0;
      vga_de_o  <= 1'b0;
      vga_hs_o  <= ~HSYNC_POL;
      vga_vs_o  <= ~VSYNC_POL;
    end else begin
      vga_rgb_o <= (de_d && vga_data_en_i) ? vga_data_i : 24'h0;
      vga_de_o  <= de_d;
      vga_hs_o  <= hs_d ? HSYNC_POL : ~HSYNC_POL;
      vga_vs_o  <= vs_d ? VSYNC_POL : ~VSYNC_POL;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen on a reduced 12x7 raster with DATA_LATENCY=2.
// Expected values come from cycle-count arithmetic; a monitor pops and compares every cycle.
`default_nettype none

module tb_vga_timing_gen;

  localparam int PW = 4;
  localparam int HA = 8;
  localparam int HF = 1;
  localparam int HS = 2;
  localparam int HB = 1;
  localparam int VA = 4;
  localparam int VF = 1;
  localparam int VS = 1;
  localparam int VB = 1;
  localparam bit HP = 1'b1;
  localparam bit VP = 1'b0;
  localparam int DL = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int NCYC = 800;
  localparam int MID_N = 2 * HT * VT + 2 * HT + 6;

  logic          clk;
  logic          rst;
  logic [PW-1:0] pix_x;
  logic [PW-1:0] pix_y;
  logic          frame_start;
  logic [23:0]   vga_data;
  logic          vga_data_en;
  logic [23:0]   vga_rgb;
  logic          vga_hs;
  logic          vga_vs;
  logic          vga_de;

  vga_timing_gen #(
    .PIX_WIDTH(PW), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HSYNC_POL(HP), .VSYNC_POL(VP), .DATA_LATENCY(DL)
  ) dut (
    .clk_i(clk), .rst_i(rst), .pix_x_o(pix_x), .pix_y_o(pix_y),
    .frame_start_o(frame_start), .vga_data_i(vga_data), .vga_data_en_i(vga_data_en),
    .vga_rgb_o(vga_rgb), .vga_hs_o(vga_hs), .vga_vs_o(vga_vs), .vga_de_o(vga_de)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [PW-1:0] x;
    logic [PW-1:0] y;
    logic          fs;
    logic          de;
    logic          hs;
    logic          vs;
    logic [23:0]   rgb;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // n = cycles elapsed since the last clock edge that saw reset.
  function automatic exp_t model(input int n, input logic en_p, input logic [23:0] d_p);
    exp_t e;
    int h, v, m, mh, mv;
    logic de, hsa, vsa;
    h = n % HT;
    v = (n / HT) % VT;
    e.x  = PW'(h);
    e.y  = PW'(v);
    e.fs = (h == 0) && (v == 0);
    de = 1'b0;
    hsa = 1'b0;
    vsa = 1'b0;
    if (n >= DL + 1) begin
      m  = n - DL - 1;
      mh = m % HT;
      mv = (m / HT) % VT;
      de  = (mh < HA) && (mv < VA);
      hsa = (mh >= HA + HF) && (mh < HA + HF + HS);
      vsa = (mv >= VA + VF) && (mv < VA + VF + VS);
    end
    e.de  = de;
    e.hs  = hsa ? HP : ~HP;
    e.vs  = vsa ? VP : ~VP;
    e.rgb = (de && en_p) ? d_p : 24'h0;
    return e;
  endfunction

  always @(negedge clk) begin
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      chk("pix_x", 24'(pix_x), 24'(mon_e.x));
      chk("pix_y", 24'(pix_y), 24'(mon_e.y));
      chk("frame_start", 24'(frame_start), 24'(mon_e.fs));
      chk("de", 24'(vga_de), 24'(mon_e.de));
      chk("hs", 24'(vga_hs), 24'(mon_e.hs));
      chk("vs", 24'(vga_vs), 24'(mon_e.vs));
      chk("rgb", vga_rgb, mon_e.rgb);
    end
  end

  initial begin
    int n;
    int rnd_rst;
    logic rst_prev, en_prev, mid_done, r, en;
    logic [23:0] d_prev, d;
    rst = 1'b1;
    vga_data = 24'h0;
    vga_data_en = 1'b0;
    rst_prev = 1'b1;
    en_prev = 1'b0;
    d_prev = 24'h0;
    mid_done = 1'b0;
    n = 0;
    rnd_rst = int'($urandom_range(620, 700));
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge clk);
      n = rst_prev ? 0 : n + 1;
      #1;
      q.push_back(model(n, en_prev, d_prev));
      r = (cyc < 3) || (cyc == rnd_rst);
      if (cyc >= 3 && !mid_done && n == MID_N) begin
        r = 1'b1;
        mid_done = 1'b1;
      end
      if (cyc >= 250 && cyc < 400) begin
        d  = 24'hFFFFFF;
        en = 1'b1;
      end else if (cyc >= 400 && cyc < 500) begin
        d  = 24'($urandom);
        en = 1'b0;
      end else begin
        d  = 24'($urandom);
        en = ($urandom_range(0, 3) != 0);
      end
      rst = r;
      vga_data = d;
      vga_data_en = en;
      rst_prev = r;
      en_prev = en;
      d_prev = d;
    end
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL queue_drain: got %0d pending expected 0", q.size());
    end
    checks++;
    if (!mid_done) begin
      failures++;
      $display("FAIL mid_reset_reached: got 0 expected 1");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
